// File: rtl/active_device_monitor_n.sv
// Multi-channel active-device counter: saturating net count, sticky clip flags, hysteresis alarm.
// Optional peak tracker (peak_clr/peak_out) is compiled in when MONITOR_PEAK_EN is defined.
module active_device_monitor_n #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int HI_TH     = 200,
  parameter int LO_TH     = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  change,
  input  logic [N_CH-1:0]  on_off,
  output logic [WIDTH-1:0] counter_out,
  output logic             alarm,
  output logic             overflow,
  output logic             underflow
`ifdef MONITOR_PEAK_EN
  ,
  input  logic             peak_clr,
  output logic [WIDTH-1:0] peak_out
`endif
);

  localparam int CW = $clog2(N_CH + 1);
  localparam int DW = CW + 1;
  localparam int SW = WIDTH + 2;

  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     HI_V  = WIDTH'(HI_TH);
  localparam logic [WIDTH-1:0]     LO_V  = WIDTH'(LO_TH);

  typedef enum logic {IDLE = 1'b0, ALARM = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          ups, downs;
  logic signed [DW-1:0]   delta;
  logic signed [SW-1:0]   sum;
  logic [WIDTH-1:0]       next_cnt;
  logic                   ovf_hit, udf_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ups   = '0;
    downs = '0;
    for (int i = 0; i < N_CH; i++) begin
      ups   = ups   + CW'(change[i] &  on_off[i]);
      downs = downs + CW'(change[i] & ~on_off[i]);
    end
  end

  assign delta = $signed({1'b0, ups}) - $signed({1'b0, downs});
  // Sign-extend delta to the widened sum so negative totals stay representable.
  assign sum   = $signed({2'b00, counter_out}) + $signed({{(SW-DW){delta[DW-1]}}, delta});

  always_comb begin
    ovf_hit  = 1'b0;
    udf_hit  = 1'b0;
    next_cnt = sum[WIDTH-1:0];
    if (sum > MAX_S) begin
      ovf_hit  = 1'b1;
      next_cnt = WIDTH'(MAX_COUNT);
    end else if (sum < 0) begin
      udf_hit  = 1'b1;
      next_cnt = '0;
    end
  end

  // Alarm decision uses the post-clamp count so alarm and counter_out move together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (next_cnt >= HI_V) state_d = ALARM;
      ALARM:   if (next_cnt <= LO_V) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_out <= '0;
      state_q     <= IDLE;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      counter_out <= next_cnt;
      state_q     <= state_d;
      if (ovf_hit) overflow  <= 1'b1;
      if (udf_hit) underflow <= 1'b1;
    end
  end

  assign alarm = (state_q == ALARM);

`ifdef MONITOR_PEAK_EN
  always_ff @(posedge clk) begin
    if (rst)                       peak_out <= '0;
    else if (peak_clr)             peak_out <= next_cnt;
    else if (next_cnt > peak_out)  peak_out <= next_cnt;
  end
`endif

endmodule

// File: tb/tb_active_device_monitor_n.sv
// Directed self-checking bench for active_device_monitor_n (default parameters).
module tb_active_device_monitor_n;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] change;
  logic [3:0] on_off;
  logic [7:0] counter_out;
  logic       alarm;
  logic       overflow;
  logic       underflow;
`ifdef MONITOR_PEAK_EN
  logic       peak_clr;
  logic [7:0] peak_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  active_device_monitor_n #(
    .N_CH(4), .WIDTH(8), .MAX_COUNT(255), .HI_TH(200), .LO_TH(150)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .change      (change),
    .on_off      (on_off),
    .counter_out (counter_out),
    .alarm       (alarm),
    .overflow    (overflow),
    .underflow   (underflow)
`ifdef MONITOR_PEAK_EN
    ,
    .peak_clr    (peak_clr),
    .peak_out    (peak_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of events, then sample 1 time unit after the edge.
  task automatic step(input logic [3:0] ch, input logic [3:0] oo);
    change = ch;
    on_off = oo;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] ch, input logic [3:0] oo, input int n);
    for (int i = 0; i < n; i++) step(ch, oo);
  endtask

  task automatic check_state(input string tag, input int cnt, input logic al,
                             input logic ovf, input logic udf);
    check({tag, ".count"}, counter_out, cnt);
    check({tag, ".alarm"}, alarm, al);
    check({tag, ".ovf"},   overflow, ovf);
    check({tag, ".udf"},   underflow, udf);
  endtask

  initial begin
    rst    = 1'b1;
    change = 4'h0;
    on_off = 4'h0;
`ifdef MONITOR_PEAK_EN
    peak_clr = 1'b0;
`endif

    // Reset with all channels joining: events discarded throughout.
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 4'hF);
      check_state($sformatf("reset%0d", i), 0, 1'b0, 1'b0, 1'b0);
`ifdef MONITOR_PEAK_EN
      check("reset.peak", peak_out, 0);
`endif
    end
    rst = 1'b0;

    step(4'hF, 4'hF); check("ramp1", counter_out, 4);
    step(4'hF, 4'hF); check("ramp2", counter_out, 8);
    step(4'hF, 4'hF); check("ramp3", counter_out, 12);

    step(4'hF, 4'b1010);    check("cancel", counter_out, 12);
    step(4'b0011, 4'b1100); check("down2", counter_out, 10);
    step(4'b0000, 4'hF);    check("idle_ch", counter_out, 10);

    // Alarm hysteresis: 10 -> 198 -> 199 -> 200.
    run(4'hF, 4'hF, 47);    check_state("to198", 198, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'b0001); check_state("to199", 199, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 4'b1000); check_state("to200", 200, 1'b1, 1'b0, 1'b0);
    run(4'hF, 4'h0, 12);    check_state("to152", 152, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 4'b0000); check_state("to151", 151, 1'b1, 1'b0, 1'b0);
    step(4'b0010, 4'b0000); check_state("to150", 150, 1'b0, 1'b0, 1'b0);
`ifdef MONITOR_PEAK_EN
    check("peak200", peak_out, 200);
    peak_clr = 1'b1;
    step(4'h0, 4'h0);
    peak_clr = 1'b0;
    check("peak_clr", peak_out, 150);
`else
    step(4'h0, 4'h0);
`endif
    run(4'hF, 4'hF, 1);     check_state("to154", 154, 1'b0, 1'b0, 1'b0);

    // Saturation: 154 -> 254 -> 255, then clipped increments.
    run(4'hF, 4'hF, 25);    check_state("to254", 254, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 4'b0100); check_state("to255", 255, 1'b1, 1'b0, 1'b0);
    step(4'hF, 4'b0101);    check_state("zero_at_max", 255, 1'b1, 1'b0, 1'b0);
    step(4'hF, 4'hF);       check_state("clip_hi", 255, 1'b1, 1'b1, 1'b0);
    step(4'hF, 4'h0);       check_state("ovf_sticky", 251, 1'b1, 1'b1, 1'b0);
`ifdef MONITOR_PEAK_EN
    check("peak255", peak_out, 255);
`endif

    // Mid-operation reset with events present.
    rst = 1'b1;
    step(4'hF, 4'hF);       check_state("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Underflow: net-zero at 0 is harmless, then 1 - 3 clips.
    step(4'hF, 4'b1010);    check_state("zero_at_0", 0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'b0001); check_state("to1", 1, 1'b0, 1'b0, 1'b0);
    step(4'b0111, 4'h0);    check_state("clip_lo", 0, 1'b0, 1'b0, 1'b1);
    step(4'hF, 4'b0011);    check_state("udf_sticky", 0, 1'b0, 1'b0, 1'b1);
    step(4'b1001, 4'b1001); check_state("after_udf", 2, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
